bp_fe_cache_req_arb: RTL and testbench

BP_FE_CACHE_REQ_ARB -- requirements
Module: bp_fe_cache_req_arb

---
 rtl/bp_fe_pkg.sv | 10 +
 rtl/bp_fe_rr_arb2.sv | 15 +
 rtl/bsg_counter_clear_up.sv | 23 ++
 rtl/bp_fe_cache_req_arb.sv | 137 +++++++++++++
 tb/tb_bp_fe_cache_req_arb.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end cache request arbiter.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_meta  = 2'd1,
    e_busy  = 2'd2
  } bp_fe_cache_req_arb_state_e;

endpackage

// File: rtl/bp_fe_rr_arb2.sv
// Two-input round-robin pick: on a tie the requester that did not win last time goes.
module bp_fe_rr_arb2 (
  input  logic [1:0] i_v,
  input  logic       i_prio,
  output logic       o_sel
);

  // With nobody valid the pick still follows priority so the data mux is stable.
  always_comb begin
    o_sel = ~i_prio;
    if (i_v == 2'b01)      o_sel = 1'b0;
    else if (i_v == 2'b10) o_sel = 1'b1;
  end

endmodule

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; clear and up in the same cycle gives init+1.
module bsg_counter_clear_up #(
  parameter  int max_val_p    = 255,
  parameter  int init_val_p   = 0,
  localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= ptr_width_lp'(init_val_p);
    else if (clear_i)
      count_o <= ptr_width_lp'(init_val_p) + ptr_width_lp'(up_i);
    else if (up_i)
      count_o <= count_o + ptr_width_lp'(1);
  end

endmodule

// File: rtl/bp_fe_cache_req_arb.sv
// Arbitrates two front-end requesters onto one cache engine port, tracks the
// outstanding request through metadata and completion, and runs a sticky watchdog.
//
// state   | meaning
// e_ready | no request outstanding; arbitrate and offer to the engine
// e_meta  | request accepted; forward owner's metadata until it is valid
// e_busy  | metadata sent; waiting for the engine to complete
module bp_fe_cache_req_arb
  import bp_fe_pkg::*;
#(
  parameter int req_width_p  = 64,
  parameter int meta_width_p = 8,
  parameter int timeout_p    = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [req_width_p-1:0]  req0_i,
  input  logic                    req0_v_i,
  output logic                    req0_ready_and_o,
  input  logic [meta_width_p-1:0] req0_metadata_i,
  input  logic                    req0_metadata_v_i,
  output logic                    req0_complete_o,

  input  logic [req_width_p-1:0]  req1_i,
  input  logic                    req1_v_i,
  output logic                    req1_ready_and_o,
  input  logic [meta_width_p-1:0] req1_metadata_i,
  input  logic                    req1_metadata_v_i,
  output logic                    req1_complete_o,

  output logic [req_width_p-1:0]  cache_req_o,
  output logic                    cache_req_v_o,
  input  logic                    cache_req_ready_and_i,
  output logic [meta_width_p-1:0] cache_req_metadata_o,
  output logic                    cache_req_metadata_v_o,
  input  logic                    cache_req_complete_i,
  input  logic                    cache_req_credits_full_i,

  output logic                    timeout_o
);

  localparam int cnt_width_lp = $clog2(timeout_p + 1);

  bp_fe_cache_req_arb_state_e r_state;
  logic                       r_prio;
  logic                       r_owner;
  logic                       r_timeout;

  logic                    w_sel;
  logic                    w_sel_v;
  logic                    w_offer;
  logic                    w_credit_ok;
  logic                    w_handshake;
  logic                    w_outstanding;
  logic                    w_owner_meta_v;
  logic                    w_complete;
  logic                    w_to_hit;
  logic [cnt_width_lp-1:0] w_cnt;

  bp_fe_rr_arb2 u_rr (
    .i_v    ({req1_v_i, req0_v_i}),
    .i_prio (r_prio),
    .o_sel  (w_sel)
  );

  // Outputs are quieted during reset so an abandoned request cannot leak a pulse.
  assign w_offer       = ~reset_i & (r_state == e_ready);
  assign w_credit_ok   = ~cache_req_credits_full_i;
  assign w_sel_v       = w_sel ? req1_v_i : req0_v_i;
  assign w_outstanding = (r_state == e_meta) | (r_state == e_busy);

  assign cache_req_o      = w_sel ? req1_i : req0_i;
  assign cache_req_v_o    = w_offer & w_sel_v & w_credit_ok;
  assign req0_ready_and_o = w_offer & ~w_sel & cache_req_ready_and_i & w_credit_ok;
  assign req1_ready_and_o = w_offer &  w_sel & cache_req_ready_and_i & w_credit_ok;
  assign w_handshake      = cache_req_v_o & cache_req_ready_and_i;

  assign w_owner_meta_v         = r_owner ? req1_metadata_v_i : req0_metadata_v_i;
  assign cache_req_metadata_o   = r_owner ? req1_metadata_i : req0_metadata_i;
  assign cache_req_metadata_v_o = ~reset_i & (r_state == e_meta) & w_owner_meta_v;

  assign w_complete      = ~reset_i & w_outstanding & cache_req_complete_i;
  assign req0_complete_o = w_complete & ~r_owner;
  assign req1_complete_o = w_complete &  r_owner;

  // Saturation is done by withholding up once the limit is reached.
  assign w_to_hit = (w_cnt == cnt_width_lp'(timeout_p));

  bsg_counter_clear_up #(
    .max_val_p  (timeout_p),
    .init_val_p (0)
  ) u_watchdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (w_handshake),
    .up_i    (w_outstanding & ~w_to_hit),
    .count_o (w_cnt)
  );

  assign timeout_o = ~reset_i & (r_timeout | w_to_hit);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= e_ready;
      r_prio    <= 1'b1;
      r_owner   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= r_timeout | w_to_hit;
      case (r_state)
        e_ready: begin
          if (w_handshake) begin
            r_owner <= w_sel;
            r_state <= e_meta;
          end
        end
        e_meta: begin
          if (cache_req_complete_i) begin
            r_prio  <= r_owner;
            r_state <= e_ready;
          end else if (w_owner_meta_v) begin
            r_state <= e_busy;
          end
        end
        e_busy: begin
          if (cache_req_complete_i) begin
            r_prio  <= r_owner;
            r_state <= e_ready;
          end
        end
        default: r_state <= e_ready;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_fe_cache_req_arb.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_bp_fe_cache_req_arb;

  localparam int RW = 64;
  localparam int MW = 8;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [RW-1:0] req0_i, req1_i;
  logic          req0_v_i, req1_v_i;
  logic [MW-1:0] req0_metadata_i, req1_metadata_i;
  logic          req0_metadata_v_i, req1_metadata_v_i;
  logic          cache_req_ready_and_i, cache_req_complete_i, cache_req_credits_full_i;

  logic          req0_ready_and_o, req1_ready_and_o;
  logic          req0_complete_o, req1_complete_o;
  logic [RW-1:0] cache_req_o;
  logic          cache_req_v_o;
  logic [MW-1:0] cache_req_metadata_o;
  logic          cache_req_metadata_v_o;
  logic          timeout_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_fe_cache_req_arb #(
    .req_width_p  (RW),
    .meta_width_p (MW),
    .timeout_p    (TO)
  ) dut (
    .clk_i                    (clk_i),
    .reset_i                  (reset_i),
    .req0_i                   (req0_i),
    .req0_v_i                 (req0_v_i),
    .req0_ready_and_o         (req0_ready_and_o),
    .req0_metadata_i          (req0_metadata_i),
    .req0_metadata_v_i        (req0_metadata_v_i),
    .req0_complete_o          (req0_complete_o),
    .req1_i                   (req1_i),
    .req1_v_i                 (req1_v_i),
    .req1_ready_and_o         (req1_ready_and_o),
    .req1_metadata_i          (req1_metadata_i),
    .req1_metadata_v_i        (req1_metadata_v_i),
    .req1_complete_o          (req1_complete_o),
    .cache_req_o              (cache_req_o),
    .cache_req_v_o            (cache_req_v_o),
    .cache_req_ready_and_i    (cache_req_ready_and_i),
    .cache_req_metadata_o     (cache_req_metadata_o),
    .cache_req_metadata_v_o   (cache_req_metadata_v_o),
    .cache_req_complete_i     (cache_req_complete_i),
    .cache_req_credits_full_i (cache_req_credits_full_i),
    .timeout_o                (timeout_o)
  );

  // Transaction model: is a request outstanding, has its metadata gone, who owns it,
  // who won the last completed request, and how long the current one has been open.
  bit m_out, m_meta, m_owner, m_last, m_to;
  int m_wd;
  bit e_pick, e_v, e_rdy0, e_rdy1, e_mv, e_c0, e_c1, e_to;
  logic [RW-1:0] e_req;
  logic [MW-1:0] e_md;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    req0_i = '0; req1_i = '0; req0_v_i = 0; req1_v_i = 0;
    req0_metadata_i = '0; req1_metadata_i = '0;
    req0_metadata_v_i = 0; req1_metadata_v_i = 0;
    cache_req_ready_and_i = 0; cache_req_complete_i = 0; cache_req_credits_full_i = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset_i = 1;
    tick();
    tick();
    reset_i = 0;
  endtask

  task automatic model_reset();
    m_out = 0; m_meta = 0; m_owner = 0; m_last = 1; m_wd = 0; m_to = 0;
  endtask

  task automatic model_predict();
    if (req0_v_i && req1_v_i) e_pick = !m_last;
    else if (req0_v_i)        e_pick = 0;
    else if (req1_v_i)        e_pick = 1;
    else                      e_pick = !m_last;
    e_req  = e_pick ? req1_i : req0_i;
    e_v    = !reset_i && !m_out && (e_pick ? req1_v_i : req0_v_i) && !cache_req_credits_full_i;
    e_rdy0 = !reset_i && !m_out && !e_pick && cache_req_ready_and_i && !cache_req_credits_full_i;
    e_rdy1 = !reset_i && !m_out &&  e_pick && cache_req_ready_and_i && !cache_req_credits_full_i;
    e_mv   = !reset_i && m_out && !m_meta && (m_owner ? req1_metadata_v_i : req0_metadata_v_i);
    e_md   = m_owner ? req1_metadata_i : req0_metadata_i;
    e_c0   = !reset_i && m_out && cache_req_complete_i && !m_owner;
    e_c1   = !reset_i && m_out && cache_req_complete_i &&  m_owner;
    e_to   = !reset_i && m_to;
  endtask

  task automatic model_advance();
    if (reset_i) begin
      model_reset();
    end else if (!m_out) begin
      if (e_v && cache_req_ready_and_i) begin
        m_out = 1; m_owner = e_pick; m_meta = 0; m_wd = 0;
      end
    end else begin
      m_wd++;
      if (cache_req_complete_i) begin
        m_out = 0; m_last = m_owner;
      end else if (e_mv) begin
        m_meta = 1;
      end
      if (m_wd >= TO) m_to = 1;
    end
  endtask

  task automatic test_reset();
    clr_inputs();
    reset_i = 1;
    tick();
    #1;
    n_vec++; if (cache_req_v_o !== 1'b0) begin n_err++; $display("FAIL rst_v: got %b want 0", cache_req_v_o); end
    n_vec++; if ({req0_ready_and_o, req1_ready_and_o} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", {req0_ready_and_o, req1_ready_and_o}); end
    n_vec++; if ({req0_complete_o, req1_complete_o, cache_req_metadata_v_o, timeout_o} !== 4'b0000) begin n_err++; $display("FAIL rst_misc: got %b want 0000", {req0_complete_o, req1_complete_o, cache_req_metadata_v_o, timeout_o}); end
    reset_i = 0;
    tick();
    n_vec++; if ({cache_req_v_o, req0_ready_and_o, req1_ready_and_o, req0_complete_o, req1_complete_o, cache_req_metadata_v_o, timeout_o} !== 7'b0) begin n_err++; $display("FAIL post_rst_outs: got %b want 0000000", {cache_req_v_o, req0_ready_and_o, req1_ready_and_o, req0_complete_o, req1_complete_o, cache_req_metadata_v_o, timeout_o}); end
  endtask

  task automatic test_tie_round_robin();
    logic [RW-1:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    do_reset();
    req0_i = a; req1_i = b; req0_v_i = 1; req1_v_i = 1; cache_req_ready_and_i = 1;
    #1;
    n_vec++; if (cache_req_v_o !== 1'b1) begin n_err++; $display("FAIL tie_first_v: got %b want 1", cache_req_v_o); end
    n_vec++; if (cache_req_o !== a) begin n_err++; $display("FAIL tie_first_data: got %h want %h", cache_req_o, a); end
    n_vec++; if ({req0_ready_and_o, req1_ready_and_o} !== 2'b10) begin n_err++; $display("FAIL tie_first_ready: got %b want 10", {req0_ready_and_o, req1_ready_and_o}); end
    tick();
    n_vec++; if (cache_req_v_o !== 1'b0) begin n_err++; $display("FAIL tie_meta_v: got %b want 0", cache_req_v_o); end
    req0_metadata_i = 8'h11; req0_metadata_v_i = 1;
    #1;
    n_vec++; if ({cache_req_metadata_v_o, cache_req_metadata_o} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL tie_meta_out: got %b/%h want 1/11", cache_req_metadata_v_o, cache_req_metadata_o); end
    tick();
    req0_metadata_v_i = 0; cache_req_complete_i = 1;
    #1;
    n_vec++; if ({req0_complete_o, req1_complete_o} !== 2'b10) begin n_err++; $display("FAIL tie_complete: got %b want 10", {req0_complete_o, req1_complete_o}); end
    n_vec++; if (cache_req_v_o !== 1'b0) begin n_err++; $display("FAIL tie_no_req_on_complete: got %b want 0", cache_req_v_o); end
    tick();
    cache_req_complete_i = 0;
    #1;
    n_vec++; if (cache_req_o !== b) begin n_err++; $display("FAIL tie_second_data: got %h want %h", cache_req_o, b); end
    n_vec++; if ({req0_ready_and_o, req1_ready_and_o} !== 2'b01) begin n_err++; $display("FAIL tie_second_ready: got %b want 01", {req0_ready_and_o, req1_ready_and_o}); end
    clr_inputs();
  endtask

  task automatic test_credits_full();
    do_reset();
    req0_v_i = 1; cache_req_ready_and_i = 1; cache_req_credits_full_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if ({cache_req_v_o, req0_ready_and_o} !== 2'b00) begin n_err++; $display("FAIL credits_block[%0d]: got %b want 00", i, {cache_req_v_o, req0_ready_and_o}); end
      tick();
    end
    cache_req_credits_full_i = 0;
    #1;
    n_vec++; if ({cache_req_v_o, req0_ready_and_o} !== 2'b11) begin n_err++; $display("FAIL credits_release: got %b want 11", {cache_req_v_o, req0_ready_and_o}); end
    tick();
    n_vec++; if (cache_req_v_o !== 1'b0) begin n_err++; $display("FAIL credits_accepted: got %b want 0", cache_req_v_o); end
    clr_inputs();
  endtask

  task automatic test_meta_owner();
    do_reset();
    req1_v_i = 1; cache_req_ready_and_i = 1;
    #1;
    n_vec++; if (req1_ready_and_o !== 1'b1) begin n_err++; $display("FAIL meta_grant1: got %b want 1", req1_ready_and_o); end
    tick();
    req1_v_i = 0; req0_metadata_i = 8'h3C; req0_metadata_v_i = 1;
    #1;
    n_vec++; if (cache_req_metadata_v_o !== 1'b0) begin n_err++; $display("FAIL meta_nonowner: got %b want 0", cache_req_metadata_v_o); end
    tick();
    req1_metadata_i = 8'hA5; req1_metadata_v_i = 1;
    #1;
    n_vec++; if ({cache_req_metadata_v_o, cache_req_metadata_o} !== {1'b1, 8'hA5}) begin n_err++; $display("FAIL meta_owner: got %b/%h want 1/a5", cache_req_metadata_v_o, cache_req_metadata_o); end
    tick();
    n_vec++; if (cache_req_metadata_v_o !== 1'b0) begin n_err++; $display("FAIL meta_one_cycle: got %b want 0", cache_req_metadata_v_o); end
    req0_metadata_v_i = 0; req1_metadata_v_i = 0; cache_req_complete_i = 1;
    #1;
    n_vec++; if ({req0_complete_o, req1_complete_o} !== 2'b01) begin n_err++; $display("FAIL meta_complete: got %b want 01", {req0_complete_o, req1_complete_o}); end
    tick();
    clr_inputs();
  endtask

  task automatic test_complete_in_meta();
    do_reset();
    req1_v_i = 1; cache_req_ready_and_i = 1;
    tick();
    req1_v_i = 0; req1_metadata_v_i = 1; cache_req_complete_i = 1;
    #1;
    n_vec++; if ({req0_complete_o, req1_complete_o} !== 2'b01) begin n_err++; $display("FAIL cim_pulse: got %b want 01", {req0_complete_o, req1_complete_o}); end
    tick();
    req1_metadata_v_i = 0; cache_req_complete_i = 0; req0_v_i = 1;
    #1;
    n_vec++; if ({req1_complete_o, cache_req_v_o, req0_ready_and_o} !== 3'b011) begin n_err++; $display("FAIL cim_back_ready: got %b want 011", {req1_complete_o, cache_req_v_o, req0_ready_and_o}); end
    clr_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    req0_v_i = 1; cache_req_ready_and_i = 1;
    tick();
    req0_v_i = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL to_early[%0d]: got %b want 0", i, timeout_o); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_set[%0d]: got %b want 1", i, timeout_o); end
      tick();
    end
    req0_metadata_v_i = 1;
    #1;
    n_vec++; if (cache_req_metadata_v_o !== 1'b1) begin n_err++; $display("FAIL to_state_kept: got %b want 1", cache_req_metadata_v_o); end
    tick();
    req0_metadata_v_i = 0; cache_req_complete_i = 1;
    #1;
    n_vec++; if (req0_complete_o !== 1'b1) begin n_err++; $display("FAIL to_late_complete: got %b want 1", req0_complete_o); end
    tick();
    cache_req_complete_i = 0;
    #1;
    n_vec++; if ({timeout_o, req0_complete_o} !== 2'b10) begin n_err++; $display("FAIL to_sticky: got %b want 10", {timeout_o, req0_complete_o}); end
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] a;
    a = {$urandom, $urandom};
    do_reset();
    req1_v_i = 1; cache_req_ready_and_i = 1;
    tick();
    req1_v_i = 0; req1_metadata_v_i = 1;
    tick();
    req1_metadata_v_i = 0; reset_i = 1; cache_req_complete_i = 1;
    #1;
    n_vec++; if ({req0_complete_o, req1_complete_o} !== 2'b00) begin n_err++; $display("FAIL rmid_no_pulse: got %b want 00", {req0_complete_o, req1_complete_o}); end
    tick();
    reset_i = 0;
    #1;
    n_vec++; if ({req0_complete_o, req1_complete_o} !== 2'b00) begin n_err++; $display("FAIL rmid_ready_ignores: got %b want 00", {req0_complete_o, req1_complete_o}); end
    cache_req_complete_i = 0; req0_i = a; req1_i = ~a; req0_v_i = 1; req1_v_i = 1;
    #1;
    n_vec++; if ({req0_ready_and_o, req1_ready_and_o, cache_req_o} !== {2'b10, a}) begin n_err++; $display("FAIL rmid_tie: got %b%b/%h want 10/%h", req0_ready_and_o, req1_ready_and_o, cache_req_o, a); end
    clr_inputs();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      reset_i                  = ($urandom_range(0, 99) == 0);
      req0_i                   = {$urandom, $urandom};
      req1_i                   = {$urandom, $urandom};
      req0_v_i                 = $urandom_range(0, 1);
      req1_v_i                 = $urandom_range(0, 1);
      req0_metadata_i          = MW'($urandom);
      req1_metadata_i          = MW'($urandom);
      req0_metadata_v_i        = ($urandom_range(0, 9) < 3);
      req1_metadata_v_i        = ($urandom_range(0, 9) < 3);
      cache_req_ready_and_i    = ($urandom_range(0, 9) < 7);
      cache_req_complete_i     = ($urandom_range(0, 9) < 2);
      cache_req_credits_full_i = ($urandom_range(0, 9) < 2);
      #1;
      model_predict();
      n_vec++; if (cache_req_v_o !== e_v) begin n_err++; $display("FAIL rnd_v[%0d]: got %b want %b", c, cache_req_v_o, e_v); end
      n_vec++; if (cache_req_o !== e_req) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", c, cache_req_o, e_req); end
      n_vec++; if ({req0_ready_and_o, req1_ready_and_o} !== {e_rdy0, e_rdy1}) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, req0_ready_and_o, req1_ready_and_o, e_rdy0, e_rdy1); end
      n_vec++; if (cache_req_metadata_v_o !== e_mv) begin n_err++; $display("FAIL rnd_mv[%0d]: got %b want %b", c, cache_req_metadata_v_o, e_mv); end
      if (e_mv) begin
        n_vec++; if (cache_req_metadata_o !== e_md) begin n_err++; $display("FAIL rnd_md[%0d]: got %h want %h", c, cache_req_metadata_o, e_md); end
      end
      n_vec++; if ({req0_complete_o, req1_complete_o} !== {e_c0, e_c1}) begin n_err++; $display("FAIL rnd_complete[%0d]: got %b%b want %b%b", c, req0_complete_o, req1_complete_o, e_c0, e_c1); end
      n_vec++; if (timeout_o !== e_to) begin n_err++; $display("FAIL rnd_timeout[%0d]: got %b want %b", c, timeout_o, e_to); end
      model_advance();
      tick();
    end
    clr_inputs();
    reset_i = 0;
  endtask

  initial begin
    clr_inputs();
    reset_i = 1;
    test_reset();
    test_tie_round_robin();
    test_credits_full();
    test_meta_owner();
    test_complete_in_meta();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
